// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg
//   Shared definitions for the sequential shift-add multiplier:
//   - state_t : controller states (IDLE, BUSY, DONE)
//   - cnt_w() : bit-count width, CNT_W = $clog2(WIDTH+1), so the counter can hold WIDTH
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int unsigned cnt_w(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_mult_adder.sv
// seq_mult_adder
//   N-bit ripple-carry adder made of a chain of full-adder cells.
//   Ports:
//     a, b  in  N  addends
//     cin   in  1  carry into bit 0
//     sum   out N  a + b + cin, carry out of the top bit discarded
module seq_mult_adder #(
    parameter int unsigned N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum
);

    logic carry;

    always_comb begin
        sum   = '0;
        carry = cin;
        for (int unsigned i = 0; i < N; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
    end

endmodule

// File: rtl/seq_mult.sv
// seq_mult
//   Sequential shift-add multiplier, one partial-product add per clock.
//   Operands are accepted in IDLE through a valid/ready handshake; the
//   product is held in P with out_valid high until out_ready.
//   Optional feature macro: SEQ_MULT_SIGNED_EN (adds the sgn input for
//   two's-complement operands; undefined build is unsigned only).
//   Ports:
//     clk        in   1        rising-edge clock
//     rst_n      in   1        synchronous active-low reset
//     in_valid   in   1        A/B valid
//     in_ready   out  1        high only in IDLE
//     A, B       in   WIDTH    multiplicand, multiplier
//     sgn        in   1        (SEQ_MULT_SIGNED_EN only) treat A/B as signed
//     out_valid  out  1        P holds a completed product (DONE)
//     out_ready  in   1        downstream accepts P
//     P          out  2*WIDTH  product register
//     busy       out  1        high in BUSY
module seq_mult
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
`ifdef SEQ_MULT_SIGNED_EN
    input  logic               sgn,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] P,
    output logic               busy
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = cnt_w(WIDTH);

    state_t            state, state_next;
    logic [PW-1:0]     a_reg, acc, addend, sum, result;
    logic [WIDTH-1:0]  b_reg, a_mag, b_mag;
    logic [CNT_W-1:0]  cnt;

`ifdef SEQ_MULT_SIGNED_EN
    logic          neg, neg_in;
    logic [PW-1:0] acc_neg;

    // Operate on magnitudes; the most-negative value negates to itself,
    // which read as unsigned is exactly its magnitude.
    always_comb begin
        a_mag  = (sgn && A[WIDTH-1]) ? (~A + WIDTH'(1)) : A;
        b_mag  = (sgn && B[WIDTH-1]) ? (~B + WIDTH'(1)) : B;
        neg_in = sgn & (A[WIDTH-1] ^ B[WIDTH-1]);
    end

    // Two's-complement negation of the finished accumulator: ~acc + 1.
    seq_mult_adder #(.N(PW)) u_neg (
        .a   (~acc),
        .b   ('0),
        .cin (1'b1),
        .sum (acc_neg)
    );

    always_comb result = neg ? acc_neg : acc;
`else
    always_comb begin
        a_mag  = A;
        b_mag  = B;
        result = acc;
    end
`endif

    always_comb addend = b_reg[0] ? a_reg : '0;

    seq_mult_adder #(.N(PW)) u_add (
        .a   (acc),
        .b   (addend),
        .cin (1'b0),
        .sum (sum)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // BUSY runs WIDTH add/shift edges, then one further edge (cnt == 0)
    // that registers the result and moves to DONE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)      state_next = BUSY;
            BUSY:    if (cnt == '0)     state_next = DONE;
            DONE:    if (out_ready)     state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            cnt   <= '0;
            P     <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            neg   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= PW'(a_mag);
                        b_reg <= b_mag;
                        acc   <= '0;
                        cnt   <= CNT_W'(WIDTH);
`ifdef SEQ_MULT_SIGNED_EN
                        neg   <= neg_in;
`endif
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        acc   <= sum;
                        a_reg <= a_reg << 1;
                        b_reg <= b_reg >> 1;
                        cnt   <= cnt - CNT_W'(1);
                    end else begin
                        P <= result;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state == BUSY);
        out_valid = (state == DONE);
    end

endmodule

// File: tb/tb_seq_mult.sv
module tb_seq_mult;

    localparam int unsigned W = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [7:0]  A, B;
    logic [15:0] P;
    logic        in_valid3, in_ready3, out_valid3, out_ready3, busy3;
    logic [2:0]  a3, b3;
    logic [5:0]  p3;
`ifdef SEQ_MULT_SIGNED_EN
    logic        sgn, sgn3;
`endif

    seq_mult #(.WIDTH(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B),
`ifdef SEQ_MULT_SIGNED_EN
        .sgn(sgn),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .P(P), .busy(busy)
    );

    seq_mult #(.WIDTH(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
        .A(a3), .B(b3),
`ifdef SEQ_MULT_SIGNED_EN
        .sgn(sgn3),
`endif
        .out_valid(out_valid3), .out_ready(out_ready3), .P(p3), .busy(busy3)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [15:0] exp_q[$];
    int unsigned acc_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    // Reference: exact integer product, signed interpretation when s=1.
    function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b, input bit s);
        int sa, sb;
        sa = s ? int'($signed(a)) : int'(a);
        sb = s ? int'($signed(b)) : int'(b);
        return 16'(sa * sb);
    endfunction

    // Monitor: latency on each out_valid rise, value on each handshake,
    // and stability of P/out_valid while stalled.
    logic        prev_ov = 1'b0, prev_hold = 1'b0;
    logic [15:0] prev_p = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov   = 1'b0;
            prev_hold = 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                if (acc_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL spurious_out_valid: out_valid=1 with no pending operation, expected 0");
                end else begin
                    chk("latency", cyc - acc_q.pop_front(), W + 1);
                end
            end
            if (prev_hold) begin
                chk("hold_out_valid", out_valid, 1);
                chk("hold_P", P, prev_p);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL spurious_product: P=0x%0h delivered with empty scoreboard", P);
                end else begin
                    chk("product", P, exp_q.pop_front());
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_p    = P;
            prev_ov   = out_valid;
        end
    end

    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input bit s, input bit push);
        int unsigned n = 0;
        @(posedge clk); #1;
        A = a; B = b; in_valid = 1'b1;
`ifdef SEQ_MULT_SIGNED_EN
        sgn = s;
`endif
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout: in_ready=0 after %0d cycles, expected 1", n);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (push) begin
            exp_q.push_back(ref_prod(a, b, s));
            acc_q.push_back(cyc);
        end
    endtask

    task automatic wait_drain();
        int unsigned n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int unsigned prev_acc;
        logic [7:0]  ta[3];
        logic [7:0]  tb[3];
        bit          rdone;
        ta = '{8'd255, 8'd0, 8'd1};
        tb = '{8'd255, 8'd200, 8'd1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
        in_valid3 = 1'b0; out_ready3 = 1'b0; a3 = '0; b3 = '0;
`ifdef SEQ_MULT_SIGNED_EN
        sgn = 1'b0; sgn3 = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_P", P, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_P3", p3, 0);

        // WIDTH=3: 7*7, out_valid 4 edges after accept, in_ready back after edge 5
        @(posedge clk); #1;
        in_valid3 = 1'b1; a3 = 3'd7; b3 = 3'd7; out_ready3 = 1'b1;
        @(posedge clk); #1;
        in_valid3 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("w3_in_ready_e%0d", k), in_ready3, (k == 5));
            chk($sformatf("w3_out_valid_e%0d", k), out_valid3, (k == 4));
            if (k == 4) chk("w3_product", p3, 49);
        end

        // Back-to-back with out_ready high: initiation interval WIDTH+3
        out_ready = 1'b1;
        prev_acc = 0;
        for (int i = 0; i < 3; i++) begin
            do_op(ta[i], tb[i], 1'b0, 1'b1);
            if (i > 0) chk("init_interval", cyc - prev_acc, W + 3);
            prev_acc = cyc;
        end
        wait_drain();

        // Backpressure: product held in DONE, new request waits for IDLE
        out_ready = 1'b0;
        do_op(8'd12, 8'd11, 1'b0, 1'b1);
        for (int n = 0; n < 50 && !out_valid; n++) @(negedge clk);
        fork
            do_op(8'd3, 8'd4, 1'b0, 1'b1);
            begin
                repeat (10) begin
                    @(negedge clk);
                    chk("bp_in_ready", in_ready, 0);
                    chk("bp_out_valid", out_valid, 1);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // Reset during BUSY: nothing emitted, block returns to IDLE
        do_op(8'd9, 8'd9, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_P", P, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_busy", busy, 0);
        rst_n = 1'b1;
        do_op(8'd5, 8'd6, 1'b0, 1'b1);
        wait_drain();

`ifdef SEQ_MULT_SIGNED_EN
        do_op(8'hFD, 8'd5,   1'b1, 1'b1);
        do_op(8'h80, 8'h80,  1'b1, 1'b1);
        do_op(8'd127, 8'h80, 1'b1, 1'b1);
        do_op(8'h80, 8'd2,   1'b0, 1'b1);
        wait_drain();
`endif

        // Randomized operands, gaps and downstream backpressure
        rdone = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    logic [7:0] ra, rb;
                    bit         rs;
                    ra = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
                    rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
`ifdef SEQ_MULT_SIGNED_EN
                    rs = 1'($urandom_range(0, 1));
`else
                    rs = 1'b0;
`endif
                    do_op(ra, rb, rs, 1'b1);
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                end
                rdone = 1'b1;
            end
            begin
                while (!rdone) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();
        chk("latency_queue_empty", acc_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_mult.md
# seq_mult

Parametrised sequential shift-add multiplier: WIDTH×WIDTH operands, 2·WIDTH-bit product, one partial-product add per clock. It is the scalable successor to the team's fixed-width combinational array multipliers. It trades latency for area, and is used wherever a WIDTH > 4 product is needed without a full array. Operands enter and the product leaves through valid/ready handshakes, so the block sits directly in streaming datapaths.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  operand pair A/B valid
- in_ready  out  1  block can accept operands; high only in IDLE
- A  in  WIDTH  multiplicand
- B  in  WIDTH  multiplier
- out_valid  out  1  P holds a completed product
- out_ready  in  1  downstream accepts P
- P  out  2·WIDTH  product register
- busy  out  1  high in BUSY state

## Operation
- FSM has three states: IDLE, BUSY, DONE.
- Accept occurs when in_valid && in_ready on a rising edge.
  - The block latches a_reg = A (zero-extended to 2·WIDTH) and b_reg = B.
  - It clears acc to 0, loads cnt = WIDTH, and goes IDLE→BUSY.
- Each BUSY cycle:
  - If b_reg[0] = 1, then acc += a_reg (2·WIDTH-bit add, no overflow possible).
  - a_reg <<= 1, b_reg >>= 1, cnt -= 1.
  - When cnt reaches 0 on this edge: P = final acc, state goes BUSY→DONE.
- DONE: out_valid = 1, and P and out_valid hold stable until out_ready = 1. Then DONE→IDLE.
- There is no accept in the DONE-exit cycle. in_ready rises in the following cycle.
- In IDLE with in_valid = 0, the block holds: P keeps the last product, out_valid = 0.
- A and B are sampled only at accept. Changes while BUSY are ignored.
- Arithmetic is unsigned by default. Result is exact for all inputs: max (2^WIDTH−1)² fits in 2·WIDTH bits.

## Timing
- Reset (rst_n = 0 at an edge):
  - state = IDLE, acc = 0, P = 0, cnt = 0.
  - out_valid = 0, busy = 0, in_ready = 1 after that edge.
- Reset dominates all other inputs, including mid-BUSY and mid-DONE. Any in-flight product is discarded with no out_valid pulse.
- Latency: out_valid rises exactly WIDTH+1 edges after the accepting edge (WIDTH BUSY edges + 1 edge to DONE).
- With out_ready held high, the minimum initiation interval is WIDTH+3 cycles accept-to-accept.
- out_ready is ignored outside DONE.
- in_valid is ignored outside IDLE. The upstream source must hold A/B until it sees in_ready.

## Configuration
- SEQ_MULT_SIGNED_EN
  - Defined: adds input sgn (1 bit, sampled at accept).
    - sgn = 1 treats A/B as two's complement.
    - At accept the block latches |A|, |B| and neg = A[MSB] ^ B[MSB].
    - On the BUSY→DONE edge, P = neg ? −acc : acc, over 2·WIDTH bits.
    - The most-negative operand (−2^(WIDTH−1)) is handled exactly, because its magnitude fits in WIDTH unsigned bits.
    - sgn = 0 behaves as unsigned. Latency is unchanged.
  - Undefined: no sgn port, unsigned only.

## Structure
- Package seq_mult_pkg holds:
  - state enum (IDLE, BUSY, DONE)
  - counter width constant CNT_W = $clog2(WIDTH+1)
- One sub-module is natural: seq_mult_adder, a 2·WIDTH-bit ripple-carry adder built from the team's half/full-adder cells, used for acc + a_reg.
- The signed-mode negation reuses seq_mult_adder in a second instance (~acc + 1).

## Test plan
- WIDTH=3: A=7, B=7 accepted → out_valid exactly 4 edges later, P=49. in_ready low for cycles 1..5 after accept.
- WIDTH=8: A=255, B=255 → P=65025. Then A=0, B=200 → P=0. Then A=1, B=1 → P=1. out_ready held high; consecutive accepts 11 cycles apart.
- Backpressure, WIDTH=8: A=12, B=11, out_ready low for 10 cycles in DONE → P=132 and out_valid remain stable. A new in_valid asserted in DONE is not accepted until IDLE.
- Reset mid-op: rst_n low at BUSY cycle 3 → next edge state IDLE, P=0, out_valid=0, in_ready=1. No product emitted. A following op A=5, B=6 yields 30.
- SEQ_MULT_SIGNED_EN, WIDTH=8, sgn=1:
  - A=−3, B=5 → P=16'hFFF1
  - A=−128, B=−128 → P=16384
  - A=127, B=−128 → P=16'hC080
  - sgn=0, A=8'h80, B=2 → P=256
